// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// pc_gen
//   Fetch-address generator: aligned fetch blocks, prioritised redirects,
//   one-entry pending-redirect buffer and instruction-address-error flag.
//   Revision: 1.0
// ============================================================================
module pc_gen #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000,
    parameter logic [31:0] EXC_VEC  = 32'hbfc00380,
    parameter int          FETCH_N  = 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               stall,
    input  logic               br_take,
    input  logic [31:0]        br_target,
    input  logic               exc_oc,
    input  logic               eret,
    input  logic [31:0]        epc,
    input  logic               if_addr_ok,
    output logic               if_req,
    output logic [31:0]        if_addr,
    output logic [FETCH_N-1:0] fetch_mask,
    output logic               adel,
    output logic               pend_valid
);

    localparam int          B          = $clog2(FETCH_N * 4);
    localparam logic [31:0] c_blk      = 32'(FETCH_N * 4);
    localparam logic [31:0] c_off_mask = c_blk - 32'd1;

    logic [31:0] r_pc;
    logic        r_pend_valid;
    logic [31:0] r_pend_addr;

    logic        w_redir;
    logic [31:0] w_tgt;
    logic        w_acc;
    logic [31:0] w_seq;

    always_comb begin
        w_tgt = br_target;
        if (eret) begin
            w_tgt = epc;
        end else if (exc_oc) begin
            w_tgt = EXC_VEC;
        end
    end

    assign w_redir = eret | exc_oc | br_take;
    assign if_req  = !stall && resetn;
    assign w_acc   = if_req && if_addr_ok;
    // Next block always starts from the aligned base, so a misaligned pc self-corrects.
    assign w_seq   = (r_pc & ~c_off_mask) + c_blk;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pc         <= RESET_PC;
            r_pend_valid <= 1'b0;
            r_pend_addr  <= 32'd0;
        end else if (w_acc && w_redir) begin
            r_pc         <= w_tgt;
            r_pend_valid <= 1'b0;
        end else if (w_acc) begin
            r_pc         <= r_pend_valid ? r_pend_addr : w_seq;
            r_pend_valid <= 1'b0;
        end else if (if_req && w_redir) begin
            // Request outstanding: pc must stay stable until accepted.
            r_pend_addr  <= w_tgt;
            r_pend_valid <= 1'b1;
        end else if (!if_req && w_redir) begin
            r_pc         <= w_tgt;
            r_pend_valid <= 1'b0;
        end else if (!if_req && r_pend_valid) begin
            r_pc         <= r_pend_addr;
            r_pend_valid <= 1'b0;
        end
    end

    generate
        if (FETCH_N == 1) begin : g_single
            assign fetch_mask = 1'b1;
        end else begin : g_multi
            for (genvar i = 0; i < FETCH_N; i++) begin : g_slot
                localparam logic [B-3:0] c_idx = (B-2)'(i);
                assign fetch_mask[i] = (r_pc[B-1:2] <= c_idx);
            end
        end
    endgenerate

    assign if_addr    = r_pc;
    assign adel       = |r_pc[1:0];
    assign pend_valid = r_pend_valid;

endmodule
`default_nettype wire

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-address generator for the MIPS-compatible CPU front end. It replaces the single-issue PC register and adds several things it lacked: a configurable fetch width with aligned fetch blocks, configurable reset and exception vectors, a valid/accept handshake with the instruction-fetch interface, a one-entry pending-redirect buffer, and misalignment flagging. It sits between the redirect sources (branch unit, exception/ERET logic) and the instruction SRAM/cache request port.

## Interface
- RESET_PC, 32'hbfc00000, address loaded on reset
- EXC_VEC, 32'hbfc00380, exception entry address
- FETCH_N, 1, instructions per fetch block; legal values 1, 2, 4
- clk  in  1  clock
- resetn  in  1  reset: resetn, synchronous, active-low; clock clk
- stall  in  1  front end cannot issue; suppresses if_req
- br_take  in  1  branch/jump redirect
- br_target  in  32  branch/jump target
- exc_oc  in  1  exception redirect to EXC_VEC
- eret  in  1  ERET redirect
- epc  in  32  ERET target
- if_addr_ok  in  1  fetch port accepts the current request
- if_req  out  1  fetch request valid
- if_addr  out  32  fetch address; equals the internal pc register
- fetch_mask  out  FETCH_N  valid-slot mask for the block at if_addr
- adel  out  1  if_addr[1:0] != 0, which is an instruction address error
- pend_valid  out  1  pending redirect held

## Operation
- B = log2(FETCH_N*4). seq(pc) = {pc[31:B]+1, B'b0}, which is the next aligned block. Wraps modulo 2^32: 32'hfffffff0 with FETCH_N=4 gives 0.
- Redirect priority: eret (epc) > exc_oc (EXC_VEC) > br_take (br_target). redir = eret|exc_oc|br_take. tgt is the winner.
- if_req = !stall && !rst_cycle, where rst_cycle is 1 during any cycle with resetn=0.
- acc = if_req && if_addr_ok.
- Register update each clock, applying the first matching rule:
  1. resetn=0: pc<=RESET_PC, pend_valid<=0, pend_addr<=0.
  2. acc && redir: pc<=tgt, pend_valid<=0.
  3. acc: pc <= pend_valid ? pend_addr : seq(pc), pend_valid<=0.
  4. if_req && !acc && redir: pc holds, because the address must stay stable until accepted. pend_addr<=tgt, pend_valid<=1. Any older pending entry is overwritten.
  5. !if_req && redir: pc<=tgt, pend_valid<=0.
  6. !if_req && pend_valid: pc<=pend_addr, pend_valid<=0.
  7. Otherwise pc holds.
- fetch_mask[i] = (i >= pc[B-1:2]) for i in 0..FETCH_N-1. FETCH_N=1 gives a constant 1.
- A misaligned target is loaded unchanged and adel=1. Its seq() still uses the aligned base, so the next block is aligned and adel clears.
- The block keeps no wrong-path or delay-slot knowledge. Flushing is the consumer's job.

## Timing
- All state is registered. if_req, fetch_mask and adel are combinational from registers plus stall/resetn. No input-to-if_addr combinational path exists.
- Reset values: if_addr=RESET_PC, pend_valid=0, adel=RESET_PC[1]|RESET_PC[0]. if_req=0 while resetn=0.
- First request: the first cycle with resetn=1 and stall=0 shows if_req=1, if_addr=RESET_PC.
- Redirect latency:
  - 1 cycle when accepted or stalled.
  - When the request is held unaccepted, the target appears the cycle after the acceptance.
- If redir and acc occur in the same cycle as pend_valid=1, the new tgt wins and the pending entry is dropped.
- If reset arrives mid-handshake, it wins. Pending is cleared and there is no request that cycle.
- if_addr and fetch_mask stay stable while if_req=1 and if_addr_ok=0.

## Test plan
- Reset, FETCH_N=1: hold resetn=0 for 3 cycles, then release with if_addr_ok=1 -> if_req=0 during reset; then if_addr runs bfc00000, bfc00004, bfc00008.
- FETCH_N=4, br_take to 32'h80000008 with acc -> next if_addr=80000008, fetch_mask=4'b1100; then 80000010 with mask 4'b1111.
- Priority: eret=1 (epc=32'h80001234), exc_oc=1 and br_take=1 all in one cycle -> if_addr=80001234, adel=0. With exc_oc and br_take only -> bfc00380.
- Pending redirect: if_req=1, if_addr_ok=0, br_take to 32'h80000100 -> pend_valid=1 and if_addr unchanged. Two cycles later if_addr_ok=1 -> next if_addr=80000100, pend_valid=0.
- Stall path: stall=1 with pend_valid=1 (pend_addr=80000200) -> if_req=0, and next cycle if_addr=80000200. A redirect during stall loads directly.
- Wrap and misalign:
  - pc=32'hfffffffc, FETCH_N=1, acc -> if_addr=0.
  - br_target=32'h80000002 -> adel=1; after acc, if_addr=80000004 and adel=0.
